// File: rtl/sgd_error_stage.sv
// -----------------------------------------------------------------------------
// sgd_error_stage
//
// Error-computation stage feeding the SGD weight-update stages. It collects
// NUM_CHUNKS partial dot-product beats (w.x) for one sample, subtracts the
// label y, scales by the learning rate mu and presents
//   err = (mu * (w.x - y)) >>> MU_SHIFT
// as the broadcast data_in operand. One sample is in flight at a time.
//
// Build option:
//   SGD_ERR_SATURATE_EN  defined   -> scaled error clamps to the signed range
//                                     of bitwidth bits
//                        undefined -> low bitwidth bits kept (two's wrap)
//   Timing and ports are identical in both builds.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   psum_valid  partial-sum beat valid
//   psum_ready  stage accepts a beat (IDLE/ACCUM only, low in reset)
//   psum_in     partial dot product of one chunk (signed)
//   y_in        label, sampled on the final beat only (signed)
//   mu          learning rate, sampled on the final beat only (unsigned)
//   err_valid   err_out valid
//   err_ready   downstream consumes err_out
//   err_out     registered scaled error (signed)
//   beat_cnt    index of the next expected beat
//   busy        high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module sgd_error_stage #(
  parameter int bitwidth      = 16,
  parameter int inputBitwidth = 8,
  parameter int NUM_CHUNKS    = 4,
  parameter int MU_SHIFT      = 8,
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid,
  output logic                     psum_ready,
  input  logic [bitwidth-1:0]      psum_in,
  input  logic [bitwidth-1:0]      y_in,
  input  logic [inputBitwidth-1:0] mu,
  output logic                     err_valid,
  input  logic                     err_ready,
  output logic [bitwidth-1:0]      err_out,
  output logic [CW-1:0]            beat_cnt,
  output logic                     busy
);

  // Accumulator carries 4 guard bits so up to 16 full-scale beats cannot wrap.
  localparam int AW = bitwidth + 4;
  // Product keeps full precision of the widened difference times unsigned mu,
  // so the clamp in the saturating build sees the true magnitude.
  localparam int PW = AW + inputBitwidth + 1;

`ifdef SGD_ERR_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, HOLD} state_t;

  state_t                    state, state_next;
  logic                      ready_c;
  logic signed [AW-1:0]      acc, diff;
  logic [inputBitwidth-1:0]  mu_q;
  logic signed [AW-1:0]      psum_ext, y_ext, sum_next;
  logic                      accept, last_beat, final_beat;
  logic signed [PW-1:0]      prod, shifted;
  logic                      pos_ovf, neg_ovf;
  logic [bitwidth-1:0]       err_sized;

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state/output decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_next = state;
    ready_c    = 1'b0;
    unique case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (psum_valid) state_next = (NUM_CHUNKS == 1) ? SCALE : ACCUM;
      end
      ACCUM: begin
        ready_c = 1'b1;
        if (psum_valid && last_beat) state_next = SCALE;
      end
      SCALE: state_next = HOLD;
      HOLD:  if (err_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gating with rst keeps the stage from advertising ready while held in reset.
  assign psum_ready = ready_c & rst;
  assign busy       = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign accept     = psum_valid && psum_ready;
  assign last_beat  = (beat_cnt == CW'(NUM_CHUNKS - 1));
  assign final_beat = accept && (((state == IDLE) && (NUM_CHUNKS == 1)) ||
                                 ((state == ACCUM) && last_beat));

  assign psum_ext = AW'($signed(psum_in));
  assign y_ext    = AW'($signed(y_in));
  // Beat 0 (accepted in IDLE) starts a fresh sum rather than adding to acc.
  assign sum_next = ((state == IDLE) ? '0 : acc) + psum_ext;

  assign prod    = $signed(diff) * $signed({1'b0, mu_q});
  assign shifted = prod >>> MU_SHIFT;
  // Result fits in bitwidth bits only if all bits above the sign bit agree.
  assign pos_ovf = !shifted[PW-1] && (|shifted[PW-2:bitwidth-1]);
  assign neg_ovf =  shifted[PW-1] && !(&shifted[PW-2:bitwidth-1]);

  always_comb begin
    err_sized = shifted[bitwidth-1:0];
    if (SATURATE && pos_ovf) err_sized = {1'b0, {(bitwidth-1){1'b1}}};
    if (SATURATE && neg_ovf) err_sized = {1'b1, {(bitwidth-1){1'b0}}};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      diff      <= '0;
      mu_q      <= '0;
      beat_cnt  <= '0;
      err_out   <= '0;
      err_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc <= sum_next;
        if (final_beat) begin
          diff     <= sum_next - y_ext;
          mu_q     <= mu;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
      if (state == SCALE) begin
        err_out   <= err_sized;
        err_valid <= 1'b1;
      end
      if ((state == HOLD) && err_ready) err_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sgd_error_stage.sv
// -----------------------------------------------------------------------------
// tb_sgd_error_stage
//
// Scoreboard bench for sgd_error_stage (NUM_CHUNKS=4, MU_SHIFT=8). The stimulus
// process pushes the expected err for every sample it issues; a monitor pops
// and compares on each err handshake and checks err_out stays stable while
// held. Directed samples use hand-computed results; random samples use a
// plain-integer reference model. Honours SGD_ERR_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_sgd_error_stage;

  localparam int NC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        psum_valid;
  logic        psum_ready;
  logic [15:0] psum_in;
  logic [15:0] y_in;
  logic [7:0]  mu;
  logic        err_valid;
  logic        err_ready;
  logic [15:0] err_out;
  logic [1:0]  beat_cnt;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          rand_ready = 1'b0;
  bit          hold_seen  = 1'b0;
  logic [15:0] hold_val;

  sgd_error_stage #(
    .bitwidth(16), .inputBitwidth(8), .NUM_CHUNKS(NC), .MU_SHIFT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
    .y_in(y_in), .mu(mu),
    .err_valid(err_valid), .err_ready(err_ready), .err_out(err_out),
    .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Reference: exact integer sum, wrapped to the 20-bit accumulator, minus y,
  // times mu, floor-divided by 2^8, then clamped or truncated to 16 bits.
  function automatic logic [15:0] model(input logic [15:0] ps[NC],
                                        input logic [15:0] y, input logic [7:0] m);
    longint s = 0;
    longint p;
    longint r;
    for (int i = 0; i < NC; i++) s += longint'($signed(ps[i]));
    s -= longint'($signed(y));
    s = s % (64'sd1 <<< 20);
    if (s < 0) s += (64'sd1 <<< 20);
    if (s >= (64'sd1 <<< 19)) s -= (64'sd1 <<< 20);
    p = s * longint'(m);
    r = p >>> 8;
`ifdef SGD_ERR_SATURATE_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r[15:0];
  endfunction

  // Presents one beat and returns one cycle after it was accepted.
  task automatic drive_beat(input logic [15:0] p, input logic [15:0] y, input logic [7:0] m);
    bit ok = 1'b0;
    psum_valid = 1'b1;
    psum_in    = p;
    y_in       = y;
    mu         = m;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (psum_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    psum_valid = 1'b0;
    psum_in    = 16'($urandom);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got no psum_ready expected accept within 200 cycles");
    end
  endtask

  // bub < 0 selects random bubbles of 0..2 cycles between beats. y/mu are
  // scrambled on non-final beats; only the final-beat values may matter.
  task automatic send_sample(input logic [15:0] ps[NC], input logic [15:0] y,
                             input logic [7:0] m, input logic [15:0] exp_v, input int bub);
    exp_q.push_back(exp_v);
    for (int i = 0; i < NC; i++) begin
      int nb = (bub < 0) ? int'($urandom_range(0, 2)) : bub;
      if (i > 0) repeat (nb) begin @(posedge clk); #1; end
      if (i == NC - 1) drive_beat(ps[i], y, m);
      else             drive_beat(ps[i], 16'($urandom), 8'($urandom));
    end
  endtask

  // Monitor: compares on every handshake, checks stability while stalled.
  initial forever begin
    @(negedge clk);
    if (rst && err_valid) begin
      if (hold_seen) check("err_stable", 32'(err_out), 32'(hold_val));
      hold_seen = 1'b1;
      hold_val  = err_out;
      if (err_ready) begin
        hold_seen = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_err: got 0x%0h expected no output", err_out);
        end else begin
          check("err_out", 32'(err_out), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      hold_seen = 1'b0;
    end
  end

  // Random downstream backpressure during the random phase.
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) err_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [15:0] ps[NC];
    logic [15:0] y;
    logic [7:0]  m;
    int          wait_n;

    rst = 1'b0; psum_valid = 1'b0; psum_in = '0; y_in = '0; mu = '0; err_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_err_valid",  32'(err_valid),  32'd0);
    check("rst_psum_ready", 32'(psum_ready), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_beat_cnt",   32'(beat_cnt),   32'd0);
    check("rst_err_out",    32'(err_out),    32'd0);
    rst = 1'b1;
    #1;
    check("idle_psum_ready", 32'(psum_ready), 32'd1);

    // Mid-sample reset after two beats
    drive_beat(16'd500, 16'd0, 8'd0);
    drive_beat(16'd700, 16'd0, 8'd0);
    check("mid_beat_cnt", 32'(beat_cnt), 32'd2);
    check("mid_busy",     32'(busy),     32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy",      32'(busy),      32'd0);
    check("midrst_beat_cnt",  32'(beat_cnt),  32'd0);
    check("midrst_err_valid", 32'(err_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic sample held under backpressure: (100-60)*128>>8 = 20
    ps = '{16'd10, 16'd20, 16'd30, 16'd40};
    send_sample(ps, 16'd60, 8'd128, 16'd20, 0);
    check("lat_scale_valid", 32'(err_valid), 32'd0);
    check("lat_scale_busy",  32'(busy),      32'd1);
    @(posedge clk);
    #1;
    check("lat_valid", 32'(err_valid), 32'd1);
    check("basic_err", 32'(err_out),   32'd20);
    psum_valid = 1'b1;
    psum_in    = 16'd1234;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_valid",      32'(err_valid),  32'd1);
      check("bp_err",        32'(err_out),    32'd20);
      check("bp_psum_ready", 32'(psum_ready), 32'd0);
      check("bp_beat_cnt",   32'(beat_cnt),   32'd0);
    end
    psum_valid = 1'b0;
    err_ready  = 1'b1;
    @(posedge clk);
    #1;
    check("release_valid", 32'(err_valid), 32'd0);
    check("release_busy",  32'(busy),      32'd0);

    // Negative: (4-100)*255 = -24480, floor(/256) = -96
    ps = '{16'd1, 16'd1, 16'd1, 16'd1};
    send_sample(ps, 16'd100, 8'd255, 16'hFFA0, 0);

    // Bubbles between every beat: same result as the basic sample
    ps = '{16'd10, 16'd20, 16'd30, 16'd40};
    send_sample(ps, 16'd60, 8'd128, 16'd20, 1);

    // Overflow: 0x1FFFC*255 >> 8 = 0x1FDFC
    ps = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
`ifdef SGD_ERR_SATURATE_EN
    send_sample(ps, 16'd0, 8'd255, 16'h7FFF, 0);
`else
    send_sample(ps, 16'd0, 8'd255, 16'hFDFC, 0);
`endif

    // Random samples with random bubbles and backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NC; i++)
        ps[i] = (k % 2 == 0) ? 16'($urandom) : 16'($signed(int'($urandom_range(0, 2000)) - 1000));
      y = 16'($urandom);
      m = 8'($urandom);
      send_sample(ps, y, m, model(ps, y, m), -1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    err_ready = 1'b1;

    // Drain
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 200) begin
      @(posedge clk);
      wait_n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
